p_layer_stream: RTL
===================

# p_layer_stream

Parametrised, streaming PRESENT-family bit-permutation layer with forward/inverse mode selectable per beat. Accepts a WIDTH-bit state over a valid/ready handshake, applies the generalised PRESENT permutation (or its inverse), and delivers the result through a 2-entry registered output buffer. It sits between the S-box layer and the round-key adder in encrypt and decrypt round datapaths, and supports back-pressure at full throughput.

## Interface
- WIDTH, 64, state width in bits.
  - Must be a multiple of 4 and at least 8; any other value is an elaboration-time error.
- clock  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  upstream beat valid.
- in_ready  output  1  block can accept a beat this cycle.
- in_data  input  WIDTH  state to permute.
- in_inv  input  1  0 = forward permutation, 1 = inverse; sampled with the beat.
- out_valid  output  1  out_data holds a permuted beat.
- out_ready  input  1  downstream accepts the beat.
- out_data  output  WIDTH  permuted state.
- out_inv  output  1  mode bit travelling with the beat.

## Operation
- Let M = WIDTH-1 and Q = WIDTH/4.
- Forward map: input bit i goes to output bit P(i).
  - P(i) = (i*Q) mod M for i < M.
  - P(M) = M.
- Inverse map: input bit j goes to output bit (j*4) mod M for j < M; bit M is fixed.
  - This is exact because Q*4 = WIDTH ≡ 1 mod M.
- For WIDTH = 64 this is the standard PRESENT pLayer: bit i goes to 16i mod 63, and bit 63 is fixed.
- push = in_valid & in_ready; pop = out_valid & out_ready.
- The permutation is applied combinationally on in_data and written into the buffer on push. Buffer entries always hold already-permuted data plus the inv bit.
- Buffer: head register (drives out_data/out_inv) and skid register; occupancy count is 0..2.
  - push, no pop: the entry goes to head if count = 0, otherwise to skid. count increments.
  - pop, no push: skid moves to head if count = 2. count decrements.
  - push and pop with count = 1: the new entry replaces head; count stays 1.
  - push and pop with count = 2: cannot occur, because in_ready = 0.
- out_valid = (count != 0).
- While out_valid = 1 and out_ready = 0, out_data and out_inv are held stable.
- in_ready is a register: next value is (count_next != 2).
- No combinational path from in_* to out_*, or from out_ready to in_ready.

## Timing
- Reset (reset_n low, asynchronous):
  - count = 0, out_valid = 0, in_ready = 0.
  - out_data = 0, out_inv = 0, skid contents = 0.
- First rising edge after reset release sets in_ready = 1.
- Latency: a beat pushed at edge n is visible at out_valid/out_data after edge n (one cycle).
- Throughput: 1 beat/cycle while out_ready = 1.
- With out_ready held low:
  - Exactly 2 beats are accepted.
  - in_ready falls after the edge that accepts the second beat.
  - in_ready rises again after the edge where a pop occurs.
- Reset asserted mid-operation: all buffered beats are discarded; outputs return to reset values immediately, without waiting for a clock edge.
- in_inv is sampled per beat; mixed forward/inverse beats may be back-to-back.

## Structure
- Shared package present_pkg holds:
  - the P_FWD/P_INV index functions (WIDTH-parametrised, constant-evaluable);
  - the WIDTH legality check;
  - the localparams M and Q.
- Sub-module p_perm:
  - purely combinational;
  - parameter WIDTH;
  - ports data_in, inv, data_out;
  - generate loop wiring both maps, with a 2:1 mux on inv.
- Top level p_layer_stream contains the handshake, count, and buffer registers.

## Test plan
- Forward, WIDTH = 64: 64'h0000_0000_0000_0002 → 64'h0000_0000_0001_0000. 64'h8000_0000_0000_0001 → unchanged. Output appears one cycle after accept.
- Inverse, WIDTH = 64: 64'h0000_0000_0001_0000 with in_inv = 1 → 64'h0000_0000_0000_0002, out_inv = 1.
- Round trip: 64'h0123_4567_89AB_CDEF forward, then the result inverse → 64'h0123_4567_89AB_CDEF. Also run 1000 random vectors with mixed in_inv against a reference model.
- WIDTH = 16 instance: 16'h0002 forward → 16'h0010; 16'h0010 inverse → 16'h0002.
- Back-pressure:
  - Hold out_ready = 0 and stream beats A, B, C. Only A and B are accepted; in_ready = 0 on the following cycle; out_data = perm(A) is held stable.
  - Release out_ready. Outputs are perm(A), perm(B), perm(C) in order, with no loss or duplication.
- Reset mid-stream:
  - Assert reset_n = 0 with count = 2. out_valid, in_ready, and out_data go to 0 without a clock edge.
  - After release: in_ready = 1 at the first edge, and no stale beat is ever output.

Source files
------------

// File: rtl/present_pkg.sv
// Shared definitions for the PRESENT-family bit-permutation layer:
// width legality, default sizing constants and the forward/inverse index maps.
package present_pkg;

  // Default state width and its derived constants (M = WIDTH-1, Q = WIDTH/4)
  localparam int DEFAULT_WIDTH = 64;
  localparam int M = DEFAULT_WIDTH - 1;
  localparam int Q = DEFAULT_WIDTH / 4;

  // A state width is usable only if it is a whole number of nibbles and at least two of them
  function automatic bit width_ok(input int width);
    return (width >= 8) && ((width % 4) == 0);
  endfunction

  // Forward map: bit i lands on (i*Q) mod M, the top bit stays where it is
  function automatic int p_fwd(input int i, input int width);
    if (i == width - 1) return width - 1;
    return (i * (width / 4)) % (width - 1);
  endfunction

  // Inverse map: bit j lands on (j*4) mod M, exact because Q*4 = WIDTH = 1 mod M
  function automatic int p_inv(input int j, input int width);
    if (j == width - 1) return width - 1;
    return (j * 4) % (width - 1);
  endfunction

endpackage

// File: rtl/p_perm.sv
// Purely combinational PRESENT bit permutation, forward or inverse selected by inv.
module p_perm
  import present_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] data_in,
  input  logic             inv,
  output logic [WIDTH-1:0] data_out
);

  logic [WIDTH-1:0] fwd_map;
  logic [WIDTH-1:0] inv_map;

  // Both maps are pure wiring; each is a bijection so every output bit has one driver
  for (genvar i = 0; i < WIDTH; i++) begin : g_wire
    assign fwd_map[p_fwd(i, WIDTH)] = data_in[i];
    assign inv_map[p_inv(i, WIDTH)] = data_in[i];
  end

  assign data_out = inv ? inv_map : fwd_map;

endmodule

// File: rtl/p_layer_stream.sv
// Streaming PRESENT permutation layer: valid/ready input, permute on accept,
// and a 2-entry registered output buffer (head + skid) for full-rate back-pressure.
module p_layer_stream
  import present_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_inv,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_inv
);

  if (!width_ok(WIDTH)) begin : g_bad_width
    $error("p_layer_stream: WIDTH must be a multiple of 4 and at least 8");
  end

  logic [WIDTH-1:0] perm_data;

  logic [1:0]       count;
  logic [1:0]       count_next;
  logic             ready_q;
  logic             ready_next;
  logic [WIDTH-1:0] head_data;
  logic [WIDTH-1:0] head_data_next;
  logic             head_inv;
  logic             head_inv_next;
  logic [WIDTH-1:0] skid_data;
  logic [WIDTH-1:0] skid_data_next;
  logic             skid_inv;
  logic             skid_inv_next;
  logic             push;
  logic             pop;

  p_perm #(
    .WIDTH(WIDTH)
  ) u_perm (
    .data_in (in_data),
    .inv     (in_inv),
    .data_out(perm_data)
  );

  // Buffer bookkeeping: decide where an accepted beat goes and whether skid advances to head
  always_comb begin
    count_next     = count;
    head_data_next = head_data;
    head_inv_next  = head_inv;
    skid_data_next = skid_data;
    skid_inv_next  = skid_inv;
    push           = in_valid & ready_q;
    pop            = (count != 2'd0) & out_ready;

    if (push && !pop) begin
      if (count == 2'd0) begin
        head_data_next = perm_data;
        head_inv_next  = in_inv;
      end else begin
        skid_data_next = perm_data;
        skid_inv_next  = in_inv;
      end
      count_next = count + 2'd1;
    end else if (!push && pop) begin
      if (count == 2'd2) begin
        head_data_next = skid_data;
        head_inv_next  = skid_inv;
      end
      count_next = count - 2'd1;
    end else if (push && pop) begin
      // in_ready is low at count 2, so this only happens with a single entry held
      head_data_next = perm_data;
      head_inv_next  = in_inv;
    end

    ready_next = (count_next != 2'd2);
  end

  // State registers; reset empties the buffer and withholds in_ready until the first edge
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count     <= 2'd0;
      ready_q   <= 1'b0;
      head_data <= '0;
      head_inv  <= 1'b0;
      skid_data <= '0;
      skid_inv  <= 1'b0;
    end else begin
      count     <= count_next;
      ready_q   <= ready_next;
      head_data <= head_data_next;
      head_inv  <= head_inv_next;
      skid_data <= skid_data_next;
      skid_inv  <= skid_inv_next;
    end
  end

  assign in_ready  = ready_q;
  assign out_valid = (count != 2'd0);
  assign out_data  = head_data;
  assign out_inv   = head_inv;

endmodule
